// File: rtl/sgm_frame_sequencer_pkg.sv
// Shared types and constants for the SGM frame sequencer.
// It holds the sequencer state encoding, the penalty width and the current core latency.
package sgm_frame_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } seqState_t;

    localparam int PenaltyW       = 6;
    localparam int DefaultCoreLat = 6;

endpackage

// File: rtl/sgm_valid_pipe.sv
// Enable-gated valid shift register that tracks which core pipeline slots hold real pixels.
// The top bit is the output valid. A consumed output whose slot cannot shift out is dropped with drain.
module sgm_valid_pipe #(
    parameter int Depth = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic din,
    input  logic drain,
    output logic dout
);

    logic [Depth-1:0] vld;

    // A consumed output is cleared during an input bubble so it is not delivered twice.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            vld <= '0;
        end else if (en) begin
            vld <= (vld << 1) | Depth'(din);
        end else if (drain) begin
            vld[Depth-1] <= 1'b0;
        end
    end

    assign dout = vld[Depth-1];

endmodule

// File: rtl/sgm_frame_sequencer.sv
// Frame controller for the SGM aggregation core: pixel admission, edge strobes and penalty hold.
// It also tracks pipeline latency for a backpressured disparity stream and flushes at end of frame.
module sgm_frame_sequencer
    import sgm_frame_sequencer_pkg::*;
#(
    parameter int ImageW    = 640,
    parameter int ImageH    = 480,
    parameter int dispLevel = 32,
    parameter int CoreLat   = DefaultCoreLat
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [PenaltyW-1:0] cfg_p1,
    input  logic [PenaltyW-1:0] cfg_p2,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                core_en,
    output logic                core_edge,
    output logic [PenaltyW-1:0] core_p1,
    output logic [PenaltyW-1:0] core_p2,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last,
    output logic                busy,
    output logic                frame_done
);

    localparam int XW    = $clog2(ImageW);
    localparam int YW    = $clog2(ImageH);
    localparam int FW    = $clog2(CoreLat + 1);
    localparam int OW    = $clog2(ImageW * ImageH + 1);
    localparam int Total = ImageW * ImageH;
    localparam logic [31:0] EdgeCols = 32'(dispLevel);

    seqState_t           state;
    logic [XW-1:0]       x;
    logic [YW-1:0]       y;
    logic [FW-1:0]       flushCnt;
    logic [OW-1:0]       outCnt;
    logic [PenaltyW-1:0] p1Reg;
    logic [PenaltyW-1:0] p2Reg;

    logic pipeOut;
    logic stall;
    logic accept;
    logic flushEn;
    logic handshake;
    logic startAcc;
    logic lastCol;
    logic lastRow;

    assign stall     = out_valid & ~out_ready;
    assign in_ready  = ~rst & (state == RUN) & ~stall;
    assign accept    = in_valid & in_ready;
    assign flushEn   = ~rst & (state == FLUSH) & ~stall;
    assign core_en   = accept | flushEn;
    assign core_edge = accept & (({{(32-XW){1'b0}}, x} < EdgeCols) | (y == '0));
    assign handshake = out_valid & out_ready;
    assign startAcc  = ~rst & (state == IDLE) & start;
    assign lastCol   = (x == XW'(ImageW - 1));
    assign lastRow   = (y == YW'(ImageH - 1));

    // Every output is forced low while reset is held, not only after the reset edge.
    assign out_valid  = ~rst & pipeOut;
    assign out_last   = out_valid & (outCnt == OW'(Total - 1));
    assign busy       = ~rst & (state != IDLE);
    assign frame_done = ~rst & (state == DONE);
    assign core_p1    = rst ? '0 : p1Reg;
    assign core_p2    = rst ? '0 : p2Reg;

    sgm_valid_pipe #(
        .Depth(CoreLat)
    ) u_validPipe (
        .clk  (clk),
        .rst  (rst),
        .clr  (startAcc),
        .en   (core_en),
        .din  (accept),
        .drain(handshake & ~core_en),
        .dout (pipeOut)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            x        <= '0;
            y        <= '0;
            flushCnt <= '0;
            outCnt   <= '0;
            p1Reg    <= '0;
            p2Reg    <= '0;
        end else begin
            if (handshake) begin
                outCnt <= outCnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= RUN;
                        x        <= '0;
                        y        <= '0;
                        flushCnt <= '0;
                        outCnt   <= '0;
                        p1Reg    <= cfg_p1;
                        p2Reg    <= cfg_p2;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (lastCol) begin
                            x <= '0;
                            if (lastRow) begin
                                state <= FLUSH;
                            end else begin
                                y <= y + 1'b1;
                            end
                        end else begin
                            x <= x + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    // Only unstalled cycles advance the core, so only they count toward the flush.
                    if (flushEn) begin
                        if (flushCnt == FW'(CoreLat - 1)) begin
                            state    <= DONE;
                            flushCnt <= '0;
                        end else begin
                            flushCnt <= flushCnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sgm_frame_sequencer.sv
// Directed bench for sgm_frame_sequencer on an 8x4 frame with 4 edge columns and a 3-cycle core.
// A cycle table covers reset, start and an early stall; frame tasks cover the multi-cycle cases.
module tb_sgm_frame_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [5:0] cfg_p1 = '0;
    logic [5:0] cfg_p2 = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       core_en;
    logic       core_edge;
    logic [5:0] core_p1;
    logic [5:0] core_p2;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       out_last;
    logic       busy;
    logic       frame_done;

    int nVec = 0;
    int nFail = 0;

    int cyc = 0;
    int acc = 0;
    int outs = 0;
    int lastAt = -1;
    int lastCnt = 0;
    int firstAcc = -1;
    int lastAcc = -1;
    int firstVld = -1;
    int doneCyc = -1;
    logic [5:0] expP1 = '0;
    logic [5:0] expP2 = '0;

    typedef struct packed {
        logic       rst;
        logic       start;
        logic       inValid;
        logic       outReady;
        logic [5:0] p1;
        logic [5:0] p2;
        logic [6:0] flags;
        logic [5:0] eP1;
        logic [5:0] eP2;
    } vec_t;

    vec_t tbl [9];

    always #5 clk = ~clk;

    sgm_frame_sequencer #(
        .ImageW(8),
        .ImageH(4),
        .dispLevel(4),
        .CoreLat(3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cfg_p1    (cfg_p1),
        .cfg_p2    (cfg_p2),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .core_en   (core_en),
        .core_edge (core_edge),
        .core_p1   (core_p1),
        .core_p2   (core_p2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .frame_done(frame_done)
    );

    task automatic chk(input string name, input int act, input int exp);
        nVec++;
        if (act != exp) begin
            nFail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int expEdge(input int n);
        return (((n % 8) < 4) || ((n / 8) == 0)) ? 1 : 0;
    endfunction

    // Called at the falling edge: tracks frame statistics and checks per-cycle rules.
    task automatic observe();
        cyc++;
        if (rst) begin
            doneCyc = -1;
        end else begin
            if (start && busy === 1'b0) begin
                acc = 0; outs = 0; lastAt = -1; lastCnt = 0;
                firstAcc = -1; lastAcc = -1; firstVld = -1; doneCyc = -1;
                expP1 = cfg_p1; expP2 = cfg_p2;
            end
            if (busy === 1'b1) begin
                chk("core_p1 held", int'(core_p1), int'(expP1));
                chk("core_p2 held", int'(core_p2), int'(expP2));
            end
            if (in_valid && in_ready) begin
                chk("core_en on accept", int'(core_en), 1);
                chk($sformatf("core_edge pixel %0d", acc), int'(core_edge), expEdge(acc));
                if (firstAcc < 0) firstAcc = cyc;
                lastAcc = cyc;
                acc++;
            end else if (in_ready) begin
                chk("core_en in bubble", int'(core_en), 0);
                chk("core_edge in bubble", int'(core_edge), 0);
            end
            if (out_valid && !out_ready) begin
                chk("in_ready in stall", int'(in_ready), 0);
                chk("core_en in stall", int'(core_en), 0);
            end
            if (out_valid && out_ready) begin
                outs++;
                if (firstVld < 0) firstVld = cyc;
                if (out_last) begin
                    lastAt = outs;
                    lastCnt++;
                end
            end
            if (frame_done) doneCyc = cyc;
        end
    endtask

    task automatic step();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
    endtask

    task automatic runFrame(input int mode, input bit doStart, input int p1, input int p2);
        if (doStart) begin
            start = 1'b1; cfg_p1 = 6'(p1); cfg_p2 = 6'(p2);
            in_valid = 1'b0; out_ready = 1'b1;
            step();
            if (mode != 3) start = 1'b0;
        end
        for (int i = 0; i < 300; i++) begin
            in_valid  = (mode == 2) ? (i % 2 == 0) : 1'b1;
            out_ready = (mode == 1) ? !(i >= 10 && i < 15) : 1'b1;
            if (mode == 3) begin
                start = 1'b1; cfg_p1 = 6'(i); cfg_p2 = 6'(63 - i);
            end
            step();
            if (doneCyc >= 0) break;
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk($sformatf("mode%0d frame_done seen", mode), int'(doneCyc >= 0), 1);
        chk($sformatf("mode%0d output count", mode), outs, 32);
        chk($sformatf("mode%0d out_last index", mode), lastAt, 32);
        chk($sformatf("mode%0d out_last pulses", mode), lastCnt, 1);
        chk($sformatf("mode%0d accept count", mode), acc, 32);
        chk($sformatf("mode%0d flush length", mode), doneCyc - lastAcc, 4);
        if (mode == 0 && doStart) begin
            chk("first valid latency", firstVld - firstAcc, 3);
            chk("frame length", doneCyc - firstAcc, 35);
        end
        @(negedge clk);
        chk($sformatf("mode%0d idle after done", mode), int'(busy), 0);
        chk($sformatf("mode%0d frame_done width", mode), int'(frame_done), 0);
        observe();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // flags = {in_ready, core_en, core_edge, out_valid, out_last, busy, frame_done}
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0,  7'b0000000, 6'd0, 6'd0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 6'd5, 6'd20, 7'b0000000, 6'd0, 6'd0};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 6'd5, 6'd20, 7'b1110010, 6'd5, 6'd20};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 6'd5, 6'd20, 7'b1110010, 6'd5, 6'd20};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 6'd5, 6'd20, 7'b1110010, 6'd5, 6'd20};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 6'd5, 6'd20, 7'b1111010, 6'd5, 6'd20};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 6'd9, 6'd33, 7'b1111010, 6'd5, 6'd20};
        tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 6'd9, 6'd33, 7'b0001010, 6'd5, 6'd20};
        tbl[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 6'd9, 6'd33, 7'b1111010, 6'd5, 6'd20};

        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) begin
            rst = tbl[i].rst; start = tbl[i].start;
            in_valid = tbl[i].inValid; out_ready = tbl[i].outReady;
            cfg_p1 = tbl[i].p1; cfg_p2 = tbl[i].p2;
            @(negedge clk);
            chk($sformatf("row%0d flags", i),
                int'({in_ready, core_en, core_edge, out_valid, out_last, busy, frame_done}),
                int'(tbl[i].flags));
            chk($sformatf("row%0d core_p1", i), int'(core_p1), int'(tbl[i].eP1));
            chk($sformatf("row%0d core_p2", i), int'(core_p2), int'(tbl[i].eP2));
            observe();
            @(posedge clk);
            #1;
        end
        start = 1'b0;

        runFrame(0, 1'b0, 0, 0);
        runFrame(0, 1'b1, 5, 20);
        runFrame(1, 1'b1, 7, 33);
        runFrame(2, 1'b1, 12, 40);

        start = 1'b1; cfg_p1 = 6'd11; cfg_p2 = 6'd22; out_ready = 1'b1; in_valid = 1'b0;
        step();
        start = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("accepts before reset", acc, 10);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("post-reset flags",
            int'({in_ready, core_en, core_edge, out_valid, out_last, busy, frame_done}), 0);
        chk("post-reset core_p1", int'(core_p1), 0);
        chk("post-reset core_p2", int'(core_p2), 0);
        observe();
        @(posedge clk);
        #1;
        in_valid = 1'b0;

        runFrame(0, 1'b1, 3, 9);
        runFrame(3, 1'b1, 5, 20);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
